// File: rtl/if_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// if_fetch_unit_pkg
//
// Shared RISC-V front-end definitions used by the instruction fetch unit:
//   - OPCODE_I and the canonical NOP (addi x0, x0, 0) built from it
//   - default reset PC
//   - fetch FSM state encodings (BOOT, RUN, HOLD) and the matching enum
//   - align_word(): clears the two low bits of a byte address
//
// No ports (package).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

package if_fetch_unit_pkg;

   localparam logic [6:0]  OPCODE_I         = 7'b001_0011;
   localparam logic [31:0] NOP_INST         = {12'd0, 5'd0, 3'b000, 5'd0, OPCODE_I};
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   localparam logic [1:0]  ST_BOOT = 2'd0;
   localparam logic [1:0]  ST_RUN  = 2'd1;
   localparam logic [1:0]  ST_HOLD = 2'd2;

   typedef enum logic [1:0] {
      BOOT = ST_BOOT,
      RUN  = ST_RUN,
      HOLD = ST_HOLD
   } fetch_state_t;

   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_fetch_unit_next_pc.sv
// ---------------------------------------------------------------------------
// if_next_pc
//
// Combinational fetch-address selection for the IF stage.
//   - Resolves redirect priority (EX branch/jalr beats ID jal).
//   - Forces redirect targets to word alignment and flags misaligned ones.
//   - Decides whether a fetch is issued this cycle and at which address.
//
// Ports:
//   state        in   current fetch FSM state
//   pause        in   hazard stall
//   pc           in   next sequential address to issue
//   ex_redirect  in   EX redirect request,  ex_target its byte target
//   id_redirect  in   ID redirect request,  id_target its byte target
//   redirect     out  any redirect this cycle
//   misaligned   out  redirect target had nonzero low bits
//   issue        out  a fetch is issued this cycle
//   issue_addr   out  byte address issued (word aligned)
//   issue_next   out  issue_addr + 4 (wraps modulo 2^32)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module if_next_pc
   import if_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  fetch_state_t state,
   input  logic         pause,
   input  logic [31:0]  pc,
   input  logic         ex_redirect,
   input  logic [31:0]  ex_target,
   input  logic         id_redirect,
   input  logic [31:0]  id_target,
   output logic         redirect,
   output logic         misaligned,
   output logic         issue,
   output logic [31:0]  issue_addr,
   output logic [31:0]  issue_next
);

   logic [31:0] target;

   // A redirect always issues, even while paused; BOOT issues unconditionally
   // because there is no response yet that a pause would need to protect.
   always_comb begin
      target     = ex_redirect ? ex_target : id_target;
      redirect   = ex_redirect | id_redirect;
      misaligned = redirect & (target[1:0] != 2'b00);
      issue      = redirect | (state == BOOT) | ~pause;
      if (redirect) begin
         issue_addr = align_word(target);
      end else if (state == BOOT) begin
         issue_addr = RESET_PC;
      end else begin
         issue_addr = pc;
      end
      issue_next = issue_addr + 32'd4;
   end

endmodule

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction fetch stage in front of a synchronous instruction ROM
// (one-cycle read latency). Issues one fetch per cycle, holds the fetched
// instruction in a skid register across hazard stalls, and restarts on
// redirects from EX (branch/jalr) or ID (jal).
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   pause_i                   hazard stall (same signal as IF/ID pause)
//   ex_redirect_i/ex_target_i redirect from EX (highest priority)
//   id_redirect_i/id_target_i redirect from ID
//   imem_en_o/imem_addr_o     ROM read enable and word address
//   imem_rdata_i              ROM data, valid one cycle after imem_en_o
//   IF_pc4_o/IF_inst_o        address+4 and instruction to IF/ID
//   IF_valid_o                IF_inst_o is a real fetched instruction
//   flush_o                   IF/ID flush (same cycle as a redirect)
//   misalign_o                sticky: a redirect target was misaligned
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module if_fetch_unit
   import if_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          IMEM_AW  = 14
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               pause_i,
   input  logic               ex_redirect_i,
   input  logic [31:0]        ex_target_i,
   input  logic               id_redirect_i,
   input  logic [31:0]        id_target_i,
   output logic               imem_en_o,
   output logic [IMEM_AW-1:0] imem_addr_o,
   input  logic [31:0]        imem_rdata_i,
   output logic [31:0]        IF_pc4_o,
   output logic [31:0]        IF_inst_o,
   output logic               IF_valid_o,
   output logic               flush_o,
   output logic               misalign_o
);

   fetch_state_t state;
   logic [31:0]  pc;
   logic [31:0]  pc_f;
   logic         resp_v;
   logic [31:0]  hold_inst;
   logic         hold_v;
   logic         misalign;

   logic         redirect;
   logic         misaligned;
   logic         issue;
   logic [31:0]  issue_addr;
   logic [31:0]  issue_next;

   if_next_pc #(
      .RESET_PC (RESET_PC)
   ) u_next_pc (
      .state       (state),
      .pause       (pause_i),
      .pc          (pc),
      .ex_redirect (ex_redirect_i),
      .ex_target   (ex_target_i),
      .id_redirect (id_redirect_i),
      .id_target   (id_target_i),
      .redirect    (redirect),
      .misaligned  (misaligned),
      .issue       (issue),
      .issue_addr  (issue_addr),
      .issue_next  (issue_next)
   );

   // Any issued fetch (boot, sequential, pause release or redirect) makes
   // the issued address the one in flight; this also discards whatever the
   // ROM was about to return and drops the skid contents on redirect.
   // The skid register is loaded only on the first paused cycle, while the
   // ROM data still belongs to pc_f.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= BOOT;
         pc        <= RESET_PC;
         pc_f      <= 32'd0;
         resp_v    <= 1'b0;
         hold_inst <= NOP_INST;
         hold_v    <= 1'b0;
         misalign  <= 1'b0;
      end else begin
         misalign <= misalign | misaligned;
         if (issue) begin
            pc_f   <= issue_addr;
            pc     <= issue_next;
            resp_v <= 1'b1;
            hold_v <= 1'b0;
            state  <= RUN;
         end else if (state == RUN && resp_v) begin
            hold_inst <= imem_rdata_i;
            hold_v    <= 1'b1;
            state     <= HOLD;
         end
      end
   end

   // Reset forces the ROM enable and flush low even though the FSM sits in
   // BOOT and the redirect inputs may be active.
   always_comb begin
      imem_en_o   = rstn & issue;
      imem_addr_o = issue_addr[IMEM_AW+1:2];
      flush_o     = rstn & redirect;
      misalign_o  = misalign;
   end

   // In HOLD the ROM output no longer belongs to pc_f, so the skid copy is
   // presented, including the release cycle.
   always_comb begin
      IF_inst_o  = NOP_INST;
      IF_pc4_o   = 32'd0;
      IF_valid_o = 1'b0;
      if (state == HOLD) begin
         IF_inst_o  = hold_inst;
         IF_pc4_o   = pc_f + 32'd4;
         IF_valid_o = hold_v;
      end else if (resp_v) begin
         IF_inst_o  = imem_rdata_i;
         IF_pc4_o   = pc_f + 32'd4;
         IF_valid_o = 1'b1;
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
`timescale 1ns/1ps

module tb_if_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam int          AW     = 14;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic          clk = 1'b0;
   logic          rstn = 1'b1;
   logic          pause_i = 1'b0;
   logic          ex_redirect_i = 1'b0;
   logic [31:0]   ex_target_i = 32'd0;
   logic          id_redirect_i = 1'b0;
   logic [31:0]   id_target_i = 32'd0;
   logic          imem_en_o;
   logic [AW-1:0] imem_addr_o;
   logic [31:0]   imem_rdata_i = 32'd0;
   logic [31:0]   IF_pc4_o;
   logic [31:0]   IF_inst_o;
   logic          IF_valid_o;
   logic          flush_o;
   logic          misalign_o;

   int errors = 0;
   int checks = 0;

   // Reference model: the instruction shown is the ROM word at the last
   // issued address; a fetch is issued at boot, on redirect, or when not paused.
   logic        mBoot = 1'b1;
   logic        mValid = 1'b0;
   logic [31:0] mAddr = 32'd0;
   logic [31:0] mNext = 32'd0;
   logic        mMis = 1'b0;

   if_fetch_unit #(
      .RESET_PC (RST_PC),
      .IMEM_AW  (AW)
   ) dut (
      .clk           (clk),
      .rstn          (rstn),
      .pause_i       (pause_i),
      .ex_redirect_i (ex_redirect_i),
      .ex_target_i   (ex_target_i),
      .id_redirect_i (id_redirect_i),
      .id_target_i   (id_target_i),
      .imem_en_o     (imem_en_o),
      .imem_addr_o   (imem_addr_o),
      .imem_rdata_i  (imem_rdata_i),
      .IF_pc4_o      (IF_pc4_o),
      .IF_inst_o     (IF_inst_o),
      .IF_valid_o    (IF_valid_o),
      .flush_o       (flush_o),
      .misalign_o    (misalign_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] romWord(input logic [AW-1:0] wa);
      logic [31:0] x;
      x = 32'(wa);
      return (x * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   // Synchronous ROM; returns junk when not enabled so a stale read is visible.
   always @(posedge clk) begin
      if (imem_en_o) imem_rdata_i <= romWord(imem_addr_o);
      else           imem_rdata_i <= $urandom;
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Called at posedge+1; drives one cycle, checks at negedge, advances model.
   task automatic applyStimulus(input logic p, input logic er, input logic [31:0] et,
                                input logic ir, input logic [31:0] it);
      logic        redir;
      logic [31:0] tgt;
      logic        iss;
      logic [31:0] issAddr;
      pause_i       = p;
      ex_redirect_i = er;
      ex_target_i   = et;
      id_redirect_i = ir;
      id_target_i   = it;
      redir   = er | ir;
      tgt     = er ? et : it;
      iss     = redir | mBoot | ~p;
      issAddr = redir ? (tgt & 32'hFFFF_FFFC) : (mBoot ? RST_PC : mNext);
      @(negedge clk);
      checkOutput("imem_en", 32'(imem_en_o), 32'(iss));
      if (iss) checkOutput("imem_addr", 32'(imem_addr_o), 32'(issAddr[AW+1:2]));
      checkOutput("flush", 32'(flush_o), 32'(redir));
      checkOutput("valid", 32'(IF_valid_o), 32'(mValid));
      checkOutput("misalign", 32'(misalign_o), 32'(mMis));
      if (mValid) begin
         checkOutput("pc4", IF_pc4_o, mAddr + 32'd4);
         checkOutput("inst", IF_inst_o, romWord(mAddr[AW+1:2]));
      end else begin
         checkOutput("inst_nop", IF_inst_o, NOP);
      end
      if (iss) begin
         mAddr  = issAddr;
         mNext  = issAddr + 32'd4;
         mValid = 1'b1;
         mBoot  = 1'b0;
      end
      if (redir && tgt[1:0] != 2'b00) mMis = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
   endtask

   // Asserts reset with the current inputs still applied, checks the reset
   // outputs right away, then releases reset between clock edges.
   task automatic doReset();
      rstn = 1'b0;
      #1;
      checkOutput("rst_en", 32'(imem_en_o), 32'd0);
      checkOutput("rst_valid", 32'(IF_valid_o), 32'd0);
      checkOutput("rst_inst", IF_inst_o, NOP);
      checkOutput("rst_pc4", IF_pc4_o, 32'd0);
      checkOutput("rst_flush", 32'(flush_o), 32'd0);
      checkOutput("rst_misalign", 32'(misalign_o), 32'd0);
      pause_i = 1'b0;
      ex_redirect_i = 1'b0;
      id_redirect_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rstn   = 1'b1;
      mBoot  = 1'b1;
      mValid = 1'b0;
      mMis   = 1'b0;
   endtask

   function automatic logic [31:0] randTarget();
      logic [31:0] r;
      r = $urandom;
      if ($urandom_range(0, 7) == 0) return r;
      return r & 32'h0000_3FFF;
   endfunction

   initial begin
      #2;
      doReset();
      // Boot, then sequential fetch until 0x10 is presented.
      idle(5);
      // Pause three cycles while 0x10 is presented, then release.
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
      idle(3);
      // EX redirect to 0x100.
      applyStimulus(1'b0, 1'b1, 32'h0000_0100, 1'b0, 32'd0);
      idle(3);
      // EX and ID together: EX wins.
      applyStimulus(1'b0, 1'b1, 32'h0000_0200, 1'b1, 32'h0000_0300);
      idle(2);
      // Misaligned ID target.
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'h0000_0042);
      idle(3);
      // Redirect while paused, stay paused, then release.
      applyStimulus(1'b1, 1'b1, 32'h0000_0080, 1'b0, 32'd0);
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
      idle(2);
      // PC wrap across 2^32.
      applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'd0);
      idle(4);
      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom_range(0, 9) < 3), ($urandom_range(0, 19) == 0), randTarget(),
                       ($urandom_range(0, 19) == 0), randTarget());
      end
      // Reset in the middle of a hold, with a redirect pending.
      idle(2);
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
      pause_i       = 1'b1;
      ex_redirect_i = 1'b1;
      ex_target_i   = 32'h0000_0500;
      doReset();
      idle(5);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
